// File: rtl/axi_mem_arbiter.sv
// Shares one downstream AXI4 port among NUM_MASTERS upstream masters.
// Reads and writes are arbitrated independently, each by a small FSM with its own pointer.
module axi_mem_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [NUM_MASTERS-1:0][7:0]            s_axi_arlen,
    input  logic [NUM_MASTERS-1:0][2:0]            s_axi_arsize,
    input  logic [NUM_MASTERS-1:0][1:0]            s_axi_arburst,
    input  logic [NUM_MASTERS-1:0]                 s_axi_arvalid,
    output logic [NUM_MASTERS-1:0]                 s_axi_arready,
    output logic [NUM_MASTERS-1:0]                 s_axi_rvalid,
    output logic [NUM_MASTERS-1:0]                 s_axi_rlast,
    output logic [DATA_WIDTH-1:0]                  s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    input  logic [NUM_MASTERS-1:0]                 s_axi_rready,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [NUM_MASTERS-1:0][7:0]            s_axi_awlen,
    input  logic [NUM_MASTERS-1:0][2:0]            s_axi_awsize,
    input  logic [NUM_MASTERS-1:0][1:0]            s_axi_awburst,
    input  logic [NUM_MASTERS-1:0]                 s_axi_awvalid,
    output logic [NUM_MASTERS-1:0]                 s_axi_awready,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic [NUM_MASTERS-1:0]                 s_axi_wlast,
    input  logic [NUM_MASTERS-1:0]                 s_axi_wvalid,
    output logic [NUM_MASTERS-1:0]                 s_axi_wready,
    output logic [NUM_MASTERS-1:0]                 s_axi_bvalid,
    output logic [1:0]                             s_axi_bresp,
    input  logic [NUM_MASTERS-1:0]                 s_axi_bready,
    output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
    output logic [7:0]                             m_axi_awlen,
    output logic [2:0]                             m_axi_awsize,
    output logic [1:0]                             m_axi_awburst,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    output logic [DATA_WIDTH-1:0]                  m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]                m_axi_wstrb,
    output logic                                   m_axi_wlast,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    input  logic [1:0]                             m_axi_bresp,
    input  logic                                   m_axi_bvalid,
    output logic                                   m_axi_bready,
    output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
    output logic [7:0]                             m_axi_arlen,
    output logic [2:0]                             m_axi_arsize,
    output logic [1:0]                             m_axi_arburst,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
    input  logic [1:0]                             m_axi_rresp,
    input  logic                                   m_axi_rlast,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready
);
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

    // First requester at or above ptr (modulo NUM_MASTERS); ptr is ignored in fixed mode.
    function automatic logic [IW-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                           input logic [IW-1:0] ptr);
        logic [IW-1:0]          win;
        logic                   found;
        logic [NUM_MASTERS-1:0] rot;
        int unsigned            idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            idx = (FIXED_PRIORITY != 0) ? k : (k + 32'(ptr)) % NUM_MASTERS;
            rot = req >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        return win;
    endfunction

    r_state_e        r_state_q, r_state_d;
    w_state_e        w_state_q, w_state_d;
    logic [IW-1:0]   r_ptr_q, r_grant_q, r_win, r_ptr_nxt;
    logic [IW-1:0]   w_ptr_q, w_grant_q, w_win, w_ptr_nxt;
    logic            r_take, r_done, w_take, w_beat_last, w_done;
    logic [ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q;
    logic [7:0]      ar_len_q, aw_len_q;
    logic [2:0]      ar_size_q, aw_size_q;
    logic [1:0]      ar_burst_q, aw_burst_q;

    assign r_win       = pick(s_axi_arvalid, r_ptr_q);
    assign w_win       = pick(s_axi_awvalid, w_ptr_q);
    assign r_take      = (r_state_q == R_IDLE) && (|s_axi_arvalid);
    assign w_take      = (w_state_q == W_IDLE) && (|s_axi_awvalid);
    assign r_done      = (r_state_q == R_DATA) && m_axi_rvalid && s_axi_rready[r_grant_q]
                         && m_axi_rlast;
    assign w_beat_last = (w_state_q == W_DATA) && s_axi_wvalid[w_grant_q] && m_axi_wready
                         && s_axi_wlast[w_grant_q];
    assign w_done      = (w_state_q == W_RESP) && m_axi_bvalid && s_axi_bready[w_grant_q];
    assign r_ptr_nxt   = (32'(r_grant_q) == NUM_MASTERS - 1) ? '0 : r_grant_q + 1'b1;
    assign w_ptr_nxt   = (32'(w_grant_q) == NUM_MASTERS - 1) ? '0 : w_grant_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            r_ptr_q    <= '0;
            w_ptr_q    <= '0;
            r_grant_q  <= '0;
            w_grant_q  <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            if (r_take) begin
                r_grant_q  <= r_win;
                ar_addr_q  <= s_axi_araddr[r_win];
                ar_len_q   <= s_axi_arlen[r_win];
                ar_size_q  <= s_axi_arsize[r_win];
                ar_burst_q <= s_axi_arburst[r_win];
            end
            if (w_take) begin
                w_grant_q  <= w_win;
                aw_addr_q  <= s_axi_awaddr[w_win];
                aw_len_q   <= s_axi_awlen[w_win];
                aw_size_q  <= s_axi_awsize[w_win];
                aw_burst_q <= s_axi_awburst[w_win];
            end
            if (r_done) r_ptr_q <= r_ptr_nxt;
            if (w_done) w_ptr_q <= w_ptr_nxt;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (r_take) r_state_d = R_ADDR;
            R_ADDR:  if (m_axi_arready) r_state_d = R_DATA;
            R_DATA:  if (r_done) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (w_take) w_state_d = W_ADDR;
            W_ADDR:  if (m_axi_awready) w_state_d = W_DATA;
            W_DATA:  if (w_beat_last) w_state_d = W_RESP;
            W_RESP:  if (w_done) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // All handshake outputs are forced low while rst is high, even before the FSM has reset.
    always_comb begin
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        s_axi_rlast   = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        if (!rst) begin
            unique case (r_state_q)
                R_IDLE: if (r_take) s_axi_arready[r_win] = 1'b1;
                R_ADDR: m_axi_arvalid = 1'b1;
                R_DATA: begin
                    s_axi_rvalid[r_grant_q] = m_axi_rvalid;
                    s_axi_rlast[r_grant_q]  = m_axi_rlast;
                    m_axi_rready            = s_axi_rready[r_grant_q];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bvalid  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        if (!rst) begin
            unique case (w_state_q)
                W_IDLE: if (w_take) s_axi_awready[w_win] = 1'b1;
                W_ADDR: m_axi_awvalid = 1'b1;
                W_DATA: begin
                    m_axi_wvalid            = s_axi_wvalid[w_grant_q];
                    s_axi_wready[w_grant_q] = m_axi_wready;
                end
                W_RESP: begin
                    s_axi_bvalid[w_grant_q] = m_axi_bvalid;
                    m_axi_bready            = s_axi_bready[w_grant_q];
                end
                default: ;
            endcase
        end
    end

    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arlen   = ar_len_q;
    assign m_axi_arsize  = ar_size_q;
    assign m_axi_arburst = ar_burst_q;
    assign m_axi_awaddr  = aw_addr_q;
    assign m_axi_awlen   = aw_len_q;
    assign m_axi_awsize  = aw_size_q;
    assign m_axi_awburst = aw_burst_q;
    assign m_axi_wdata   = s_axi_wdata[w_grant_q];
    assign m_axi_wstrb   = s_axi_wstrb[w_grant_q];
    assign m_axi_wlast   = s_axi_wlast[w_grant_q];
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_bresp   = m_axi_bresp;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: a round-robin and a fixed-priority instance share the upstream
// stimulus; each has its own reactive memory model. Read beats go through a scoreboard queue.
module tb_axi_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ar_hold;
    always #5 clk = ~clk;

    logic [1:0][31:0] up_araddr, up_awaddr, up_wdata;
    logic [1:0][7:0]  up_arlen, up_awlen;
    logic [1:0][2:0]  up_arsize, up_awsize;
    logic [1:0][1:0]  up_arburst, up_awburst;
    logic [1:0][3:0]  up_wstrb;
    logic [1:0]       up_arvalid, up_rready, up_awvalid, up_wlast, up_wvalid, up_bready;

    logic [1:0]  up_arready[2], up_rvalid[2], up_rlast[2], up_awready[2], up_wready[2];
    logic [1:0]  up_bvalid[2], up_rresp[2], up_bresp[2];
    logic [31:0] up_rdata[2];

    logic [31:0] dn_awaddr[2], dn_araddr[2], dn_wdata[2], dn_rdata[2];
    logic [7:0]  dn_awlen[2], dn_arlen[2];
    logic [2:0]  dn_awsize[2], dn_arsize[2];
    logic [1:0]  dn_awburst[2], dn_arburst[2], dn_bresp[2], dn_rresp[2];
    logic [3:0]  dn_wstrb[2];
    logic        dn_awvalid[2], dn_awready[2], dn_wlast[2], dn_wvalid[2], dn_wready[2];
    logic        dn_bvalid[2], dn_bready[2], dn_arvalid[2], dn_arready[2];
    logic        dn_rlast[2], dn_rvalid[2], dn_rready[2];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          mst;
        logic [31:0] data;
        logic        lst;
    } rbeat_t;
    rbeat_t sb_q[$];
    rbeat_t mon_exp;
    bit     sb_en = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_mem_arbiter #(
            .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(g)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_axi_araddr(up_araddr), .s_axi_arlen(up_arlen), .s_axi_arsize(up_arsize),
            .s_axi_arburst(up_arburst), .s_axi_arvalid(up_arvalid),
            .s_axi_arready(up_arready[g]), .s_axi_rvalid(up_rvalid[g]),
            .s_axi_rlast(up_rlast[g]), .s_axi_rdata(up_rdata[g]), .s_axi_rresp(up_rresp[g]),
            .s_axi_rready(up_rready),
            .s_axi_awaddr(up_awaddr), .s_axi_awlen(up_awlen), .s_axi_awsize(up_awsize),
            .s_axi_awburst(up_awburst), .s_axi_awvalid(up_awvalid),
            .s_axi_awready(up_awready[g]),
            .s_axi_wdata(up_wdata), .s_axi_wstrb(up_wstrb), .s_axi_wlast(up_wlast),
            .s_axi_wvalid(up_wvalid), .s_axi_wready(up_wready[g]),
            .s_axi_bvalid(up_bvalid[g]), .s_axi_bresp(up_bresp[g]), .s_axi_bready(up_bready),
            .m_axi_awaddr(dn_awaddr[g]), .m_axi_awlen(dn_awlen[g]),
            .m_axi_awsize(dn_awsize[g]), .m_axi_awburst(dn_awburst[g]),
            .m_axi_awvalid(dn_awvalid[g]), .m_axi_awready(dn_awready[g]),
            .m_axi_wdata(dn_wdata[g]), .m_axi_wstrb(dn_wstrb[g]), .m_axi_wlast(dn_wlast[g]),
            .m_axi_wvalid(dn_wvalid[g]), .m_axi_wready(dn_wready[g]),
            .m_axi_bresp(dn_bresp[g]), .m_axi_bvalid(dn_bvalid[g]), .m_axi_bready(dn_bready[g]),
            .m_axi_araddr(dn_araddr[g]), .m_axi_arlen(dn_arlen[g]),
            .m_axi_arsize(dn_arsize[g]), .m_axi_arburst(dn_arburst[g]),
            .m_axi_arvalid(dn_arvalid[g]), .m_axi_arready(dn_arready[g]),
            .m_axi_rdata(dn_rdata[g]), .m_axi_rresp(dn_rresp[g]), .m_axi_rlast(dn_rlast[g]),
            .m_axi_rvalid(dn_rvalid[g]), .m_axi_rready(dn_rready[g])
        );

        // Memory model: read beat i of a burst returns araddr + i.
        logic        rd_busy;
        logic [31:0] rd_addr;
        logic [7:0]  rd_len, rd_cnt;
        logic [1:0]  wr_st;
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_busy <= 1'b0;
                rd_addr <= '0;
                rd_len  <= '0;
                rd_cnt  <= '0;
                wr_st   <= 2'd0;
            end else begin
                if (!rd_busy) begin
                    if (dn_arvalid[g] && dn_arready[g]) begin
                        rd_busy <= 1'b1;
                        rd_addr <= dn_araddr[g];
                        rd_len  <= dn_arlen[g];
                        rd_cnt  <= '0;
                    end
                end else if (dn_rvalid[g] && dn_rready[g]) begin
                    if (rd_cnt == rd_len) rd_busy <= 1'b0;
                    rd_cnt <= rd_cnt + 8'd1;
                end
                case (wr_st)
                    2'd0: if (dn_awvalid[g] && dn_awready[g]) wr_st <= 2'd1;
                    2'd1: if (dn_wvalid[g] && dn_wready[g] && dn_wlast[g]) wr_st <= 2'd2;
                    2'd2: if (dn_bvalid[g] && dn_bready[g]) wr_st <= 2'd0;
                    default: wr_st <= 2'd0;
                endcase
            end
        end
        assign dn_arready[g] = !rd_busy && !ar_hold;
        assign dn_rvalid[g]  = rd_busy;
        assign dn_rlast[g]   = rd_busy && (rd_cnt == rd_len);
        assign dn_rdata[g]   = rd_addr + {24'd0, rd_cnt};
        assign dn_rresp[g]   = 2'b00;
        assign dn_awready[g] = (wr_st == 2'd0);
        assign dn_wready[g]  = (wr_st == 2'd1);
        assign dn_bvalid[g]  = (wr_st == 2'd2);
        assign dn_bresp[g]   = 2'b00;
    end

    // Scoreboard on the round-robin instance: every delivered read beat must match the queue head.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if ($countones(up_rvalid[0]) > 1) begin
                miscompares++;
                $display("FAIL rvalid_onehot: got %b, required at most one bit", up_rvalid[0]);
            end
            for (int m = 0; m < 2; m++) begin
                if (up_rvalid[0][m] && up_rready[m]) begin
                    vectors++;
                    if (sb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rbeat_unexpected: master %0d data %h, required no beat",
                                 m, up_rdata[0]);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        if (mon_exp.mst != m || up_rdata[0] !== mon_exp.data
                            || up_rlast[0][m] !== mon_exp.lst) begin
                            miscompares++;
                            $display("FAIL rbeat: got m%0d %h last %b, required m%0d %h last %b",
                                     m, up_rdata[0], up_rlast[0][m], mon_exp.mst,
                                     mon_exp.data, mon_exp.lst);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic clear_inputs();
        up_araddr = '0; up_arlen = '0; up_arsize = '0; up_arburst = '0; up_arvalid = '0;
        up_awaddr = '0; up_awlen = '0; up_awsize = '0; up_awburst = '0; up_awvalid = '0;
        up_wdata = '0; up_wstrb = '0; up_wlast = '0; up_wvalid = '0;
        up_rready = 2'b11; up_bready = 2'b11; ar_hold = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_en = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        sb_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        up_arvalid = 2'b11; up_awvalid = 2'b11; up_wvalid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({up_arready[d], up_awready[d], up_wready[d], up_rvalid[d], up_bvalid[d],
                 dn_arvalid[d], dn_awvalid[d], dn_wvalid[d], dn_rready[d], dn_bready[d]}
                !== '0) begin
                miscompares++;
                $display("FAIL reset_handshakes dut%0d: ar %b aw %b w %b, required all 0",
                         d, up_arready[d], up_awready[d], up_wready[d]);
            end
            vectors++;
            if ({dn_araddr[d], dn_awaddr[d], dn_arlen[d], dn_awlen[d], dn_arsize[d],
                 dn_awsize[d], dn_arburst[d], dn_awburst[d]} !== '0) begin
                miscompares++;
                $display("FAIL reset_fields dut%0d: araddr %h awaddr %h, required 0",
                         d, dn_araddr[d], dn_awaddr[d]);
            end
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        up_araddr[0] = 32'h100; up_arlen[0] = 8'd3; up_arsize[0] = 3'd2; up_arvalid = 2'b01;
        for (int i = 0; i < 4; i++) sb_q.push_back('{mst: 0, data: 32'h100 + i, lst: (i == 3)});
        @(negedge clk);
        vectors++;
        if (up_arready[0] !== 2'b01 || dn_arvalid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL read_grant: arready %b m_arvalid %b, required 01 and 0",
                     up_arready[0], dn_arvalid[0]);
        end
        @(posedge clk); #1;
        up_arvalid = '0;
        @(negedge clk);
        vectors++;
        if (dn_arvalid[0] !== 1'b1 || dn_araddr[0] !== 32'h100 || dn_arlen[0] !== 8'd3
            || dn_arsize[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL read_issue: arvalid %b addr %h len %0d, required 1 100 3",
                     dn_arvalid[0], dn_araddr[0], dn_arlen[0]);
        end
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL read_drain: %0d beats outstanding, required 0", sb_q.size());
        end
        // Back in R_IDLE: a new request is granted in its first cycle.
        @(posedge clk); #1;
        up_araddr[1] = 32'h180; up_arlen[1] = 8'd0; up_arvalid = 2'b10;
        sb_q.push_back('{mst: 1, data: 32'h180, lst: 1'b1});
        @(negedge clk);
        vectors++;
        if (up_arready[0] !== 2'b10) begin
            miscompares++;
            $display("FAIL read_idle_regrant: arready %b, required 10", up_arready[0]);
        end
        @(posedge clk); #1;
        up_arvalid = '0;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL read2_drain: %0d beats outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic test_contention();
        int glog[2][$];
        do_reset();
        sb_en = 1'b0;
        up_araddr[0] = 32'h200; up_araddr[1] = 32'h300;
        up_arlen[0] = 8'd1; up_arlen[1] = 8'd1; up_arvalid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (|up_arready[d]) begin
                    vectors++;
                    if ($countones(up_arready[d]) != 1 || (|up_rvalid[d])) begin
                        miscompares++;
                        $display("FAIL grant_clean dut%0d: arready %b rvalid %b, required 1-hot/00",
                                 d, up_arready[d], up_rvalid[d]);
                    end
                    glog[d].push_back(up_arready[d][1] ? 1 : 0);
                end
            end
        end
        @(posedge clk); #1;
        up_arvalid = '0;
        repeat (8) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (glog[d].size() < 4) begin
                miscompares++;
                $display("FAIL grant_count dut%0d: %0d grants, required at least 4",
                         d, glog[d].size());
            end
            for (int i = 0; i < glog[d].size(); i++) begin
                vectors++;
                if (glog[d][i] != ((d == 0) ? (i % 2) : 0)) begin
                    miscompares++;
                    $display("FAIL grant_order dut%0d #%0d: got m%0d, required m%0d",
                             d, i, glog[d][i], (d == 0) ? (i % 2) : 0);
                end
            end
        end
    endtask

    task automatic test_parallel_write_read();
        logic [31:0] wq[$];
        bit   got_b = 1'b0, aw_seen = 1'b0, ar_hs, aw_hs, w_hs;
        int   wbeats = 0;
        do_reset();
        wq.push_back(32'hA5A5_0001);
        wq.push_back(32'hA5A5_0002);
        up_araddr[0] = 32'h500; up_arlen[0] = 8'd3; up_arvalid = 2'b01;
        for (int i = 0; i < 4; i++) sb_q.push_back('{mst: 0, data: 32'h500 + i, lst: (i == 3)});
        up_awaddr[1] = 32'h400; up_awlen[1] = 8'd1; up_awvalid = 2'b10;
        up_wdata[1] = wq[0]; up_wstrb[1] = 4'hF; up_wvalid = 2'b10;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if (up_arready[0] !== 2'b01 || up_awready[0] !== 2'b10) begin
                    miscompares++;
                    $display("FAIL parallel_grant: arready %b awready %b, required 01 10",
                             up_arready[0], up_awready[0]);
                end
            end
            ar_hs = up_arready[0][0];
            aw_hs = up_awready[0][1];
            w_hs  = up_wvalid[1] && up_wready[0][1];
            if (|up_wready[0]) begin
                vectors++;
                if (!aw_seen || up_wready[0][0]) begin
                    miscompares++;
                    $display("FAIL wready_gate: wready %b aw_done %b, required 10 after AW",
                             up_wready[0], aw_seen);
                end
            end
            if (w_hs) begin
                vectors++;
                if (wq.size() == 0 || dn_wdata[0] !== wq[0] || dn_wlast[0] !== (wbeats == 1)
                    || dn_wstrb[0] !== 4'hF) begin
                    miscompares++;
                    $display("FAIL wbeat %0d: got %h last %b, required %h last %b", wbeats,
                             dn_wdata[0], dn_wlast[0], (wq.size() != 0) ? wq[0] : 32'h0,
                             wbeats == 1);
                end
                if (wq.size() != 0) void'(wq.pop_front());
                wbeats++;
            end
            if (|up_bvalid[0]) begin
                vectors++;
                if (up_bvalid[0] !== 2'b10 || up_bresp[0] !== 2'b00 || wbeats != 2) begin
                    miscompares++;
                    $display("FAIL bresp: bvalid %b bresp %b beats %0d, required 10 00 2",
                             up_bvalid[0], up_bresp[0], wbeats);
                end
                got_b = 1'b1;
            end
            if (dn_awvalid[0] && dn_awready[0]) aw_seen = 1'b1;
            @(posedge clk); #1;
            if (ar_hs) up_arvalid = '0;
            if (aw_hs) up_awvalid = '0;
            if (w_hs) begin
                if (wq.size() != 0) begin
                    up_wdata[1] = wq[0];
                    up_wlast = 2'b10;
                end else begin
                    up_wvalid = '0;
                    up_wlast = '0;
                end
            end
            if (got_b && sb_q.size() == 0) break;
        end
        vectors++;
        if (!got_b || wbeats != 2 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL parallel_done: bresp %b wbeats %0d rbeats left %0d, required 1 2 0",
                     got_b, wbeats, sb_q.size());
        end
    endtask

    task automatic test_ar_stall();
        int m0_grants = 0;
        do_reset();
        ar_hold = 1'b1;
        up_araddr[1] = 32'h600; up_arlen[1] = 8'd0; up_arvalid = 2'b10;
        sb_q.push_back('{mst: 1, data: 32'h600, lst: 1'b1});
        sb_q.push_back('{mst: 0, data: 32'h700, lst: 1'b1});
        @(negedge clk);
        vectors++;
        if (up_arready[0] !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_grant: arready %b, required 10", up_arready[0]);
        end
        @(posedge clk); #1;
        up_araddr[0] = 32'h700; up_arlen[0] = 8'd0; up_arvalid = 2'b01;
        up_araddr[1] = 32'hDEAD_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (dn_arvalid[0] !== 1'b1 || dn_araddr[0] !== 32'h600 || up_arready[0] !== 2'b00)
            begin
                miscompares++;
                $display("FAIL stall_hold c%0d: arvalid %b addr %h arready %b, required 1 600 00",
                         c, dn_arvalid[0], dn_araddr[0], up_arready[0]);
            end
            @(posedge clk); #1;
        end
        ar_hold = 1'b0;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
            @(negedge clk);
            if (up_arready[0][0]) m0_grants++;
            @(posedge clk); #1;
            if (m0_grants != 0) up_arvalid = '0;
        end
        vectors++;
        if (sb_q.size() != 0 || m0_grants != 1) begin
            miscompares++;
            $display("FAIL stall_release: beats left %0d m0 grants %0d, required 0 1",
                     sb_q.size(), m0_grants);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        up_araddr[0] = 32'h800; up_arlen[0] = 8'd3; up_arvalid = 2'b01;
        for (int i = 0; i < 4; i++) sb_q.push_back('{mst: 0, data: 32'h800 + i, lst: (i == 3)});
        @(posedge clk); #1;
        up_arvalid = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (up_rvalid[0][0]) break;
        end
        @(posedge clk); #1;
        rst = 1'b1;  // held through the second beat
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({up_arready[0], up_rvalid[0], up_rlast[0], up_awready[0], up_wready[0],
                 up_bvalid[0], dn_arvalid[0], dn_rready[0], dn_awvalid[0], dn_wvalid[0],
                 dn_bready[0], up_rdata[0], dn_araddr[0]} !== '0) begin
                miscompares++;
                $display("FAIL post_reset c%0d: rvalid %b m_arvalid %b araddr %h, required 0",
                         c, up_rvalid[0], dn_arvalid[0], dn_araddr[0]);
            end
        end
        @(posedge clk); #1;
        up_araddr[0] = 32'h900; up_arlen[0] = 8'd0; up_arvalid = 2'b01;
        sb_q.push_back('{mst: 0, data: 32'h900, lst: 1'b1});
        @(negedge clk);
        vectors++;
        if (up_arready[0] !== 2'b01) begin
            miscompares++;
            $display("FAIL fresh_ar: arready %b, required 01", up_arready[0]);
        end
        @(posedge clk); #1;
        up_arvalid = '0;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL fresh_drain: %0d beats outstanding, required 0", sb_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_parallel_write_read();
        test_ar_stall();
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
